alu_issue_ctrl: RTL and testbench

- Multi-cycle issue controller that sits in front of the combinational ALU.
- Accepts one 16-bit instruction per handshake, reads both operands from the register file, and drives the ALU A/B/OpCode for one full cycle.
- Captures the ALU result and flags, writes the result back to the register file, and commits selected flags to the processor status register (PSR).
- Forms the producer/consumer end of the ALU OpCode/Flags interface.

---
 rtl/alu_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue controller in front of the combinational ALU: accept, read
// operands, present them for one full cycle, write the result back and commit flags.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned FLAG_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] rf_raddr_a,
  output logic [RADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [15:0]        alu_opcode,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic [FLAG_W-1:0]  alu_flags,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [FLAG_W-1:0]  psr,
  output logic               busy,
  output logic               op_err,
  output logic               err_sticky
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_ADDI   = 4'b0101;
  localparam logic [3:0] OP_SHIFTS = 4'b1000;
  localparam logic [3:0] OP_SUBI   = 4'b1001;
  localparam logic [3:0] OP_CMPI   = 4'b1011;

  localparam logic [3:0] EXT_AND    = 4'b0001;
  localparam logic [3:0] EXT_OR     = 4'b0010;
  localparam logic [3:0] EXT_XOR    = 4'b0011;
  localparam logic [3:0] EXT_ADD    = 4'b0101;
  localparam logic [3:0] EXT_CMP    = 4'b1011;
  localparam logic [3:0] EXT_LSHI_L = 4'b0000;
  localparam logic [3:0] EXT_LSHI_R = 4'b0001;
  localparam logic [3:0] EXT_LSH    = 4'b0100;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;

  logic [1:0]         state, state_nxt;
  logic [15:0]        ir, ir_nxt;
  logic [FLAG_W-1:0]  flg, flg_nxt;
  logic               instr_ready_nxt, busy_nxt;
  logic [RADDR_W-1:0] rf_raddr_a_nxt, rf_raddr_b_nxt, rf_waddr_nxt;
  logic [DATA_W-1:0]  alu_a_nxt, alu_b_nxt, rf_wdata_nxt;
  logic [15:0]        alu_opcode_nxt;
  logic               rf_we_nxt, op_err_nxt, err_sticky_nxt;
  logic [FLAG_W-1:0]  psr_nxt;

  logic op_valid, op_wr, psr_all, psr_lc;

  // Opcode class decode of the latched instruction.
  always_comb begin
    op_valid = 1'b0;
    op_wr    = 1'b0;
    psr_all  = 1'b0;
    psr_lc   = 1'b0;
    case (ir[15:12])
      OP_RTYPE: begin
        case (ir[7:4])
          EXT_ADD: begin
            op_valid = 1'b1;
            op_wr    = 1'b1;
            psr_all  = 1'b1;
          end
          EXT_AND, EXT_OR, EXT_XOR: begin
            op_valid = 1'b1;
            op_wr    = 1'b1;
          end
          EXT_CMP: begin
            op_valid = 1'b1;
            psr_lc   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        op_valid = 1'b1;
        op_wr    = 1'b1;
        psr_all  = 1'b1;
      end
      OP_CMPI: begin
        op_valid = 1'b1;
        psr_lc   = 1'b1;
      end
      OP_SHIFTS: begin
        case (ir[7:4])
          EXT_LSHI_L, EXT_LSHI_R, EXT_LSH: begin
            op_valid = 1'b1;
            op_wr    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next state and next register values; ALU-facing outputs hold outside EXEC entry.
  always_comb begin
    state_nxt      = state;
    ir_nxt         = ir;
    flg_nxt        = flg;
    rf_raddr_a_nxt = rf_raddr_a;
    rf_raddr_b_nxt = rf_raddr_b;
    alu_a_nxt      = alu_a;
    alu_b_nxt      = alu_b;
    alu_opcode_nxt = alu_opcode;
    rf_waddr_nxt   = rf_waddr;
    rf_wdata_nxt   = rf_wdata;
    psr_nxt        = psr;
    err_sticky_nxt = err_sticky;
    rf_we_nxt      = 1'b0;
    op_err_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          ir_nxt         = instr;
          rf_raddr_a_nxt = RADDR_W'(instr[11:8]);
          rf_raddr_b_nxt = RADDR_W'(instr[3:0]);
          state_nxt      = S_READ;
        end
      end
      S_READ: begin
        alu_a_nxt      = rf_rdata_a;
        alu_b_nxt      = rf_rdata_b;
        alu_opcode_nxt = ir;
        state_nxt      = S_EXEC;
      end
      S_EXEC: begin
        rf_wdata_nxt   = alu_c;
        flg_nxt        = alu_flags;
        rf_waddr_nxt   = RADDR_W'(ir[11:8]);
        rf_we_nxt      = op_wr;
        op_err_nxt     = ~op_valid;
        err_sticky_nxt = err_sticky | ~op_valid;
        state_nxt      = S_WB;
      end
      S_WB: begin
        if (psr_all) begin
          psr_nxt = flg;
        end else if (psr_lc) begin
          psr_nxt[FLAG_L:FLAG_C] = flg[FLAG_L:FLAG_C];
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    instr_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt        = (state_nxt != S_IDLE);
  end

  // State and output registers; reset drops any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      flg         <= '0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      psr         <= '0;
      op_err      <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_nxt;
      ir          <= ir_nxt;
      flg         <= flg_nxt;
      instr_ready <= instr_ready_nxt;
      busy        <= busy_nxt;
      rf_raddr_a  <= rf_raddr_a_nxt;
      rf_raddr_b  <= rf_raddr_b_nxt;
      alu_a       <= alu_a_nxt;
      alu_b       <= alu_b_nxt;
      alu_opcode  <= alu_opcode_nxt;
      rf_we       <= rf_we_nxt;
      rf_waddr    <= rf_waddr_nxt;
      rf_wdata    <= rf_wdata_nxt;
      psr         <= psr_nxt;
      op_err      <= op_err_nxt;
      err_sticky  <= err_sticky_nxt;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a register file and ALU surround the DUT,
// a reference model predicts each instruction's effects, a monitor checks them.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_opcode, alu_c, rf_wdata;
  logic [4:0]  alu_flags, psr;
  logic        rf_we, busy, op_err, err_sticky;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_c(alu_c), .alu_flags(alu_flags), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .psr(psr), .busy(busy),
    .op_err(op_err), .err_sticky(err_sticky)
  );

  // Behavioural ALU: flags {N,Z,F,L,C}; undefined ops drive all flags high.
  function automatic logic [20:0] alu_fn(input logic [15:0] ins, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] imm, y, r;
    logic [16:0] w;
    logic c, l, f, ok, add, sub, cmp;
    imm = {{8{ins[7]}}, ins[7:0]};
    y = b; r = '0; c = 0; l = 0; f = 0; ok = 1; add = 0; sub = 0; cmp = 0;
    case (ins[15:12])
      4'b0000: case (ins[7:4])
        4'b0101: add = 1;
        4'b0001: r = a & b;
        4'b0010: r = a | b;
        4'b0011: r = a ^ b;
        4'b1011: cmp = 1;
        default: ok = 0;
      endcase
      4'b0101: begin add = 1; y = imm; end
      4'b1001: begin sub = 1; y = imm; end
      4'b1011: begin cmp = 1; y = imm; end
      4'b1000: case (ins[7:4])
        4'b0000: r = a << ins[3:0];
        4'b0001: r = a >> ins[3:0];
        4'b0100: r = b[4] ? (a >> b[3:0]) : (a << b[3:0]);
        default: ok = 0;
      endcase
      default: ok = 0;
    endcase
    if (add) begin
      w = {1'b0, a} + {1'b0, y}; r = w[15:0]; c = w[16];
      f = (a[15] == y[15]) && (r[15] != a[15]);
    end
    if (sub || cmp) begin
      w = {1'b0, a} - {1'b0, y}; r = w[15:0]; c = (a >= y);
      f = (a[15] != y[15]) && (r[15] != a[15]); l = cmp && (a > y);
    end
    if (!ok) return {a ^ b, 5'b11111};
    return {r, r[15], (r == 16'd0), f, l, c};
  endfunction

  logic [15:0] rf [16];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;
  assign {alu_c, alu_flags} = alu_fn(alu_opcode, alu_a, alu_b);

  int cyc = 0, since_rst = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    since_rst <= reset ? 0 : since_rst + 1;
  end

  int n_vec = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    int          acc;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata, a, b;
    logic [4:0]  psr;
    logic        err, sticky;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] mregs [16];
  logic [4:0]  mpsr;
  logic        msticky;

  // Reference model: architectural effect of one instruction.
  task automatic push_exp(input logic [15:0] ins, input int acc);
    exp_t e;
    logic [20:0] rv;
    logic [3:0] cls, ext;
    logic all, lc;
    cls = ins[15:12]; ext = ins[7:4];
    e.ins = ins; e.acc = acc; e.waddr = ins[11:8];
    e.a = mregs[ins[11:8]]; e.b = mregs[ins[3:0]];
    rv = alu_fn(ins, e.a, e.b);
    e.wdata = rv[20:5];
    e.we = 0; e.err = 0; all = 0; lc = 0;
    case (cls)
      4'b0000: begin
        if (ext == 4'b0101) begin e.we = 1; all = 1; end
        else if (ext == 4'b0001 || ext == 4'b0010 || ext == 4'b0011) e.we = 1;
        else if (ext == 4'b1011) lc = 1;
        else e.err = 1;
      end
      4'b0101, 4'b1001: begin e.we = 1; all = 1; end
      4'b1011: lc = 1;
      4'b1000: if (ext == 4'b0000 || ext == 4'b0001 || ext == 4'b0100) e.we = 1; else e.err = 1;
      default: e.err = 1;
    endcase
    if (all) mpsr = rv[4:0];
    if (lc) mpsr[1:0] = rv[1:0];
    if (e.we) mregs[ins[11:8]] = e.wdata;
    if (e.err) msticky = 1;
    e.psr = mpsr; e.sticky = msticky;
    sbq.push_back(e);
  endtask

  // Monitor: completion of each instruction is the falling edge of busy.
  int wr_cnt = 0, wr_cyc = 0, err_cnt = 0, err_cyc = 0;
  logic [3:0] wr_addr;
  logic [15:0] wr_data, last_op, last_a, last_b;
  initial begin : monitor
    exp_t e;
    logic busy_q;
    busy_q = 0; last_op = '0; last_a = '0; last_b = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_cnt = 0; err_cnt = 0; busy_q = 0; last_op = '0; last_a = '0; last_b = '0;
      end else begin
        if (sbq.size() != 0 && cyc == sbq[0].acc + 1) begin
          check("exec_opcode", 32'(alu_opcode), 32'(sbq[0].ins));
          check("exec_a", 32'(alu_a), 32'(sbq[0].a));
          check("exec_b", 32'(alu_b), 32'(sbq[0].b));
          last_op = sbq[0].ins; last_a = sbq[0].a; last_b = sbq[0].b;
        end else begin
          check("hold_opcode", 32'(alu_opcode), 32'(last_op));
          check("hold_a", 32'(alu_a), 32'(last_a));
          check("hold_b", 32'(alu_b), 32'(last_b));
        end
        if (rf_we) begin wr_cnt++; wr_addr = rf_waddr; wr_data = rf_wdata; wr_cyc = cyc; end
        if (op_err) begin err_cnt++; err_cyc = cyc; end
        if (busy_q && !busy) begin
          if (sbq.size() == 0) begin
            check("spurious_done", 32'(sbq.size()), 32'd1);
          end else begin
            e = sbq.pop_front();
            check("wr_count", 32'(wr_cnt), 32'(e.we));
            if (e.we) begin
              check("wr_addr", 32'(wr_addr), 32'(e.waddr));
              check("wr_data", 32'(wr_data), 32'(e.wdata));
              check("wr_latency", 32'(wr_cyc - e.acc), 32'd2);
            end
            check("op_err_count", 32'(err_cnt), 32'(e.err));
            if (e.err) check("op_err_latency", 32'(err_cyc - e.acc), 32'd2);
            check("psr", 32'(psr), 32'(e.psr));
            check("err_sticky", 32'(err_sticky), 32'(e.sticky));
            check("done_latency", 32'(cyc - e.acc), 32'd3);
          end
          wr_cnt = 0; err_cnt = 0;
        end
        busy_q = busy;
        if (since_rst >= 1) check("ready_vs_busy", 32'(instr_ready), 32'(!busy));
      end
    end
  end

  task automatic send(input logic [15:0] ins, output int acc);
    int n;
    n = 0; acc = -1;
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin
      check("accept_timeout", 32'(instr_ready), 32'd1);
    end else begin
      acc = cyc + 1;
      push_exp(ins, acc);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    instr_valid = 1'b0;
    while ((sbq.size() != 0 || busy) && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] rd, rs, ext;
    logic [7:0] im;
    logic [15:0] r;
    rd = 4'($urandom); rs = 4'($urandom); im = 8'($urandom);
    case ($urandom_range(9, 0))
      0: r = {4'b0000, rd, 4'b0101, rs};
      1: r = {4'b0000, rd, 4'b0001, rs};
      2: r = {4'b0000, rd, 4'b0010, rs};
      3: r = {4'b0000, rd, 4'b0011, rs};
      4: r = {4'b0000, rd, 4'b1011, rs};
      5: r = {4'b0101, rd, im};
      6: r = {4'b1001, rd, im};
      7: r = {4'b1011, rd, im};
      8: begin
        ext = ($urandom_range(2, 0) == 0) ? 4'b0100 : {3'b000, im[0]};
        r = {4'b1000, rd, ext, rs};
      end
      default: case ($urandom_range(2, 0))
        0: r = {4'b0111, rd, im};
        1: r = {4'b0000, rd, 4'b1111, rs};
        default: r = {4'b1000, rd, 4'b1111, rs};
      endcase
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] saved [16];
    logic [15:0] r5, r6;
    int a0, a1, a2;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    rf[1] = 16'h7FFF; rf[2] = 16'h0001; rf[3] = 16'hFFFE; rf[4] = 16'h0002;
    rf[7] = 16'h0001; rf[8] = 16'hFFFF;
    r5 = rf[5]; r6 = rf[6];
    for (int i = 0; i < 16; i++) mregs[i] = rf[i];
    mpsr = '0; msticky = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psr", 32'(psr), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_err", 32'(op_err), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(instr_ready), 32'd1);

    // Reset during EXEC of ADD R1,R2: nothing written, nothing committed.
    for (int i = 0; i < 16; i++) saved[i] = mregs[i];
    send(16'h0152, a0);
    @(posedge clk); #1;
    reset = 1'b1;
    sbq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = saved[i];
    mpsr = '0; msticky = 1'b0;
    @(posedge clk); #1;
    check("midop_rf_we", 32'(rf_we), 32'd0);
    check("midop_psr", 32'(psr), 32'd0);
    check("midop_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midop_ready", 32'(instr_ready), 32'd1);
    check("midop_no_write", 32'(rf[1]), 32'h7FFF);

    send(16'h0152, a0);          // ADD R1,R2
    drain();
    check("add_result", 32'(rf[1]), 32'h8000);
    check("add_psr", 32'(psr), 32'h14);
    send(16'h03B4, a0);          // CMP R3,R4
    drain();
    check("cmp_psr", 32'(psr), 32'h17);
    check("cmp_no_write", 32'(rf[3]), 32'hFFFE);
    send(16'h0758, a0);          // ADD R7,R8 -> zero
    drain();
    check("addz_psr", 32'(psr), 32'h09);
    send(16'h0516, a0);          // AND R5,R6
    drain();
    check("and_result", 32'(rf[5]), 32'(r5 & r6));
    check("and_psr", 32'(psr), 32'h09);
    send(16'h7123, a0);          // undefined class
    drain();
    check("inv_psr", 32'(psr), 32'h09);
    check("inv_sticky", 32'(err_sticky), 32'd1);

    // instr_valid held high across three dependent instructions.
    send(16'h5103, a0);          // ADDI R1,#3
    send(16'h0951, a1);          // ADD R9,R1
    send(16'h9101, a2);          // SUBI R1,#1
    check("accept_gap_1", 32'(a1 - a0), 32'd4);
    check("accept_gap_2", 32'(a2 - a1), 32'd4);
    drain();

    for (int k = 0; k < 60; k++) begin
      int gap;
      gap = $urandom_range(2, 0);
      instr_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      send(rand_instr(), a0);
    end
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
